conv_1x1_accum_align: RTL

Parametrised channel-in accumulator and output aligner for 1x1 convolution layers. It takes the per-channel product stream from a 1x1 multiplier stage and sums CHANNEL_NUM_IN products into one output sample per (pixel, output channel). It then applies optional stride-2 decimation, rounding, saturation and optional ReLU. Results are buffered in a FIFO that releases only after a programmable fill level and honours downstream back-pressure. It sits between the conv multiplier stage and the next layer's loop-data block.

---
 rtl/conv_1x1_accum_align_if.sv | 27 ++
 rtl/conv_1x1_accum_align.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/conv_1x1_accum_align_if.sv
// Stream and status bundle between the 1x1 conv accumulator and its neighbours.
// The master drives the product stream and downstream ready; the slave is the accumulator.
interface conv_1x1_accum_align_if #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 256
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                         valid_in;
    logic signed [DATA_WIDTH-1:0] pxl_in;
    logic                         ready_in;
    logic signed [DATA_WIDTH-1:0] pxl_out;
    logic                         valid_out;
    logic [LVL_W-1:0]             fifo_level;
    logic                         overflow;
    logic                         frame_done;

    modport master (
        output valid_in, pxl_in, ready_in,
        input  pxl_out, valid_out, fifo_level, overflow, frame_done
    );

    modport slave (
        input  valid_in, pxl_in, ready_in,
        output pxl_out, valid_out, fifo_level, overflow, frame_done
    );
endinterface

// File: rtl/conv_1x1_accum_align.sv
// Channel-in accumulator and output aligner for 1x1 convolution layers.
// Sums CHANNEL_NUM_IN products per (pixel, output channel), rounds, saturates,
// optionally applies ReLU and stride-2 decimation, and buffers results in a FIFO
// that only starts releasing once START_LEVEL words have accumulated.
// FIFO_DEPTH is expected to be a power of two, at least 2.
module conv_1x1_accum_align #(
    parameter int DATA_WIDTH      = 16,
    parameter int IMAGE_WIDTH     = 64,
    parameter int IMAGE_HEIGHT    = 64,
    parameter int CHANNEL_NUM_IN  = 64,
    parameter int CHANNEL_NUM_OUT = 128,
    parameter int STRIDE          = 1,
    parameter int FRAC_SHIFT      = 8,
    parameter int RELU            = 0,
    parameter int FIFO_DEPTH      = 256,
    parameter int START_LEVEL     = 256
) (
    input logic                   clk,
    input logic                   reset,
    conv_1x1_accum_align_if.slave bus
);
    localparam int CIN_W     = (CHANNEL_NUM_IN  > 1) ? $clog2(CHANNEL_NUM_IN)  : 1;
    localparam int COUT_W    = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
    localparam int COL_W     = (IMAGE_WIDTH     > 1) ? $clog2(IMAGE_WIDTH)     : 1;
    localparam int ROW_W     = (IMAGE_HEIGHT    > 1) ? $clog2(IMAGE_HEIGHT)    : 1;
    localparam int ACC_WIDTH = DATA_WIDTH + $clog2(CHANNEL_NUM_IN) + 1;
    // One extra bit so the rounding offset can never wrap the sum.
    localparam int RW        = ACC_WIDTH + 1;
    localparam int ADDR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1;
    // Last row/column that survives decimation: the largest even index for stride 2.
    localparam int LAST_ROW  = (STRIDE == 2) ? ((IMAGE_HEIGHT - 1) / 2) * 2 : IMAGE_HEIGHT - 1;
    localparam int LAST_COL  = (STRIDE == 2) ? ((IMAGE_WIDTH  - 1) / 2) * 2 : IMAGE_WIDTH  - 1;
    localparam int RSH       = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;

    localparam logic signed [RW-1:0] ROUND_ADD =
        (FRAC_SHIFT > 0) ? signed'(RW'(1) << RSH) : '0;
    localparam logic signed [RW-1:0] SAT_MAX =
        {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN =
        {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic [CIN_W-1:0]  cin;
    logic [COUT_W-1:0] cout;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              last_cin, last_cout, last_col, last_row;

    logic signed [ACC_WIDTH-1:0]  acc, pxl_ext, final_sum;
    logic signed [RW-1:0]         sum_wide, rounded, shifted;
    logic signed [DATA_WIDTH-1:0] sat_val, result;

    logic keep, kept, frame_last;

    logic signed [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]            wr_ptr, rd_ptr;
    logic [LVL_W-1:0]             level;
    logic                         full, empty, wr_en, rd_en, release_ok, released;

    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_valid, overflow_flag, done_flag;

    assign last_cin  = (cin  == CIN_W'(CHANNEL_NUM_IN - 1));
    assign last_cout = (cout == COUT_W'(CHANNEL_NUM_OUT - 1));
    assign last_col  = (col  == COL_W'(IMAGE_WIDTH - 1));
    assign last_row  = (row  == ROW_W'(IMAGE_HEIGHT - 1));

    // Position counters: cin innermost, then cout, col, row; all wrap together at frame end.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cin  <= '0;
            cout <= '0;
            col  <= '0;
            row  <= '0;
        end else if (bus.valid_in) begin
            cin <= last_cin ? '0 : cin + 1'b1;
            if (last_cin) begin
                cout <= last_cout ? '0 : cout + 1'b1;
                if (last_cout) begin
                    col <= last_col ? '0 : col + 1'b1;
                    if (last_col)
                        row <= last_row ? '0 : row + 1'b1;
                end
            end
        end
    end

    assign pxl_ext   = {{(ACC_WIDTH-DATA_WIDTH){bus.pxl_in[DATA_WIDTH-1]}}, bus.pxl_in};
    // The first channel loads rather than adds, so no separate clear is needed between sums.
    assign final_sum = (cin == '0) ? pxl_ext : acc + pxl_ext;

    // Running channel sum.
    always_ff @(posedge clk) begin
        if (!reset)
            acc <= '0;
        else if (bus.valid_in)
            acc <= final_sum;
    end

    // Round-half-up, arithmetic shift, saturate, optional ReLU.
    always_comb begin
        sum_wide = {final_sum[ACC_WIDTH-1], final_sum};
        rounded  = sum_wide + ROUND_ADD;
        shifted  = rounded >>> FRAC_SHIFT;
        if (shifted > SAT_MAX)
            sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (shifted < SAT_MIN)
            sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            sat_val = shifted[DATA_WIDTH-1:0];
        result = sat_val;
        if ((RELU != 0) && sat_val[DATA_WIDTH-1])
            result = '0;
    end

    assign keep       = (STRIDE != 2) || (!row[0] && !col[0]);
    assign kept       = bus.valid_in && last_cin && keep;
    assign frame_last = kept && last_cout &&
                        (row == ROW_W'(LAST_ROW)) && (col == COL_W'(LAST_COL));

    assign full       = (level == LVL_W'(FIFO_DEPTH));
    assign empty      = (level == '0);
    assign wr_en      = kept && !full;
    // Threshold is looked at combinationally so the first load follows the level edge directly.
    assign release_ok = released || (level >= LVL_W'(START_LEVEL));
    assign rd_en      = release_ok && !empty && (!out_valid || bus.ready_in);

    // Buffer storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= result;
    end

    // FIFO pointers, fill level, release latch and sticky overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            released      <= 1'b0;
            overflow_flag <= 1'b0;
            done_flag     <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= (wr_ptr == ADDR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= (rd_ptr == ADDR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (level >= LVL_W'(START_LEVEL))
                released <= 1'b1;
            if (kept && full)
                overflow_flag <= 1'b1;
            done_flag <= frame_last;
        end
    end

    // Output register: loads from the FIFO head, holds while stalled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (rd_en) begin
            out_data  <= mem[rd_ptr];
            out_valid <= 1'b1;
        end else if (out_valid && bus.ready_in) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.pxl_out    = out_data;
    assign bus.valid_out  = out_valid;
    assign bus.fifo_level = level;
    assign bus.overflow   = overflow_flag;
    assign bus.frame_done = done_flag;
endmodule
